// File: rtl/fifo_pkg.sv
// Shared constants and width helpers for the parametrised synchronous FIFO.
package fifo_pkg;

    // Read-mode selectors for the FWFT parameter
    localparam int FIFO_STD  = 0;
    localparam int FIFO_FWFT = 1;

    // Pointer width: one bit per address level, wraps naturally at DEPTH
    function automatic int fifo_ptr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    // Count width: one extra bit so the full value DEPTH is representable
    function automatic int fifo_cnt_w(input int depth);
        return fifo_ptr_w(depth) + 1;
    endfunction

    // True for powers of two that are at least 2
    function automatic bit fifo_is_pow2(input int v);
        return (v >= 2) && ((v & (v - 1)) == 0);
    endfunction

endpackage

// File: rtl/fifo_mem_2p.sv
// Simple dual-port register array: synchronous write, asynchronous read.
// Contents are intentionally not reset.
module fifo_mem_2p #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8,
    parameter int AW    = 3
) (
    input  logic             clk,
    input  logic             we_i,
    input  logic [AW-1:0]    waddr_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic [AW-1:0]    raddr_i,
    output logic [WIDTH-1:0] rdata_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    // Write port: store the word on an accepted write
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/sync_fifo_param.sv
// Parametrised single-clock FIFO with guarded full/empty, thresholds,
// sticky error flags, synchronous flush and optional first-word-fall-through.
module sync_fifo_param
    import fifo_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int DEPTH     = 8,
    parameter int AF_THRESH = DEPTH - 2,
    parameter int AE_THRESH = 2,
    parameter int FWFT      = FIFO_STD
) (
    input  logic                   clk,
    input  logic                   reset_i,
    input  logic                   flush_i,
    input  logic                   wr_en_i,
    input  logic [WIDTH-1:0]       data_i,
    input  logic                   rd_en_i,
    output logic [WIDTH-1:0]       data_o,
    output logic                   rd_valid_o,
    output logic                   full_o,
    output logic                   empty_o,
    output logic                   almost_full_o,
    output logic                   almost_empty_o,
    output logic [$clog2(DEPTH):0] count_o,
    output logic                   overflow_o,
    output logic                   underflow_o,
    input  logic                   clr_err_i
);

    localparam int PTR_W = fifo_ptr_w(DEPTH);
    localparam int CNT_W = fifo_cnt_w(DEPTH);

    // Reject illegal configurations at elaboration time
    if (!fifo_is_pow2(DEPTH)) begin : g_bad_depth
        $error("sync_fifo_param: DEPTH must be a power of two >= 2");
    end
    if (AF_THRESH < 1 || AF_THRESH > DEPTH) begin : g_bad_af
        $error("sync_fifo_param: AF_THRESH must be in 1..DEPTH");
    end
    if (AE_THRESH < 0 || AE_THRESH > DEPTH - 1) begin : g_bad_ae
        $error("sync_fifo_param: AE_THRESH must be in 0..DEPTH-1");
    end

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [WIDTH-1:0] dout_q, dout_d;
    logic             rd_valid_q, rd_valid_d;
    logic             ovf_q, ovf_d;
    logic             unf_q, unf_d;

    logic             full, empty;
    logic             wa, ra;
    logic [WIDTH-1:0] mem_rdata;

    // Flags decode the registered count only
    assign full  = (count_q == CNT_W'(DEPTH));
    assign empty = (count_q == '0);

    // Flush wins over both ports; guards use the pre-edge count
    assign wa = wr_en_i & ~full  & ~flush_i;
    assign ra = rd_en_i & ~empty & ~flush_i;

    fifo_mem_2p #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .AW    (PTR_W)
    ) u_mem (
        .clk     (clk),
        .we_i    (wa),
        .waddr_i (wr_ptr_q),
        .wdata_i (data_i),
        .raddr_i (rd_ptr_q),
        .rdata_o (mem_rdata)
    );

    // Pointer and occupancy next-state
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (wa) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (ra) rd_ptr_d = rd_ptr_q + PTR_W'(1);
            unique case ({wa, ra})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // Registered read path: capture head on a pop, one-cycle valid pulse
    always_comb begin
        dout_d     = dout_q;
        rd_valid_d = 1'b0;
        if (ra && FWFT == FIFO_STD) begin
            dout_d     = mem_rdata;
            rd_valid_d = 1'b1;
        end
    end

    // Sticky errors: a new error in the same cycle as a clear keeps the flag set
    always_comb begin
        ovf_d = ovf_q;
        unf_d = unf_q;
        if (clr_err_i) begin
            ovf_d = 1'b0;
            unf_d = 1'b0;
        end
        if (wr_en_i & full)  ovf_d = 1'b1;
        if (rd_en_i & empty) unf_d = 1'b1;
    end

    // State registers with asynchronous active-low reset
    always_ff @(posedge clk or negedge reset_i) begin
        if (!reset_i) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            dout_q     <= '0;
            rd_valid_q <= 1'b0;
            ovf_q      <= 1'b0;
            unf_q      <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            dout_q     <= dout_d;
            rd_valid_q <= rd_valid_d;
            ovf_q      <= ovf_d;
            unf_q      <= unf_d;
        end
    end

    // In FWFT mode the head word is presented directly from the array
    assign data_o         = (FWFT == FIFO_FWFT) ? mem_rdata : dout_q;
    assign rd_valid_o     = (FWFT == FIFO_FWFT) ? ~empty    : rd_valid_q;
    assign full_o         = full;
    assign empty_o        = empty;
    assign almost_full_o  = (count_q >= CNT_W'(AF_THRESH));
    assign almost_empty_o = (count_q <= CNT_W'(AE_THRESH));
    assign count_o        = count_q;
    assign overflow_o     = ovf_q;
    assign underflow_o    = unf_q;

endmodule

// File: tb/tb_sync_fifo_param.sv
// Directed bench for sync_fifo_param: one standard-mode and one FWFT instance.
// Standard-mode read data is checked by a scoreboard monitor.
module tb_sync_fifo_param;
    import fifo_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset_i;

    logic       s_flush, s_wr, s_rd, s_clr;
    logic [7:0] s_din, s_dout;
    logic       s_vld, s_full, s_empty, s_af, s_ae, s_ovf, s_unf;
    logic [3:0] s_cnt;

    logic       f_flush, f_wr, f_rd, f_clr;
    logic [7:0] f_din, f_dout;
    logic       f_vld, f_full, f_empty, f_af, f_ae, f_ovf, f_unf;
    logic [3:0] f_cnt;

    sync_fifo_param #(.WIDTH(8), .DEPTH(8), .AF_THRESH(6), .AE_THRESH(2), .FWFT(FIFO_STD)) u_std (
        .clk(clk), .reset_i(reset_i), .flush_i(s_flush), .wr_en_i(s_wr), .data_i(s_din),
        .rd_en_i(s_rd), .data_o(s_dout), .rd_valid_o(s_vld), .full_o(s_full), .empty_o(s_empty),
        .almost_full_o(s_af), .almost_empty_o(s_ae), .count_o(s_cnt), .overflow_o(s_ovf),
        .underflow_o(s_unf), .clr_err_i(s_clr)
    );

    sync_fifo_param #(.WIDTH(8), .DEPTH(8), .AF_THRESH(6), .AE_THRESH(2), .FWFT(FIFO_FWFT)) u_fwft (
        .clk(clk), .reset_i(reset_i), .flush_i(f_flush), .wr_en_i(f_wr), .data_i(f_din),
        .rd_en_i(f_rd), .data_o(f_dout), .rd_valid_o(f_vld), .full_o(f_full), .empty_o(f_empty),
        .almost_full_o(f_af), .almost_empty_o(f_ae), .count_o(f_cnt), .overflow_o(f_ovf),
        .underflow_o(f_unf), .clr_err_i(f_clr)
    );

    int         n_cmp = 0;
    int         n_err = 0;
    logic [7:0] exp_q [$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Scoreboard monitor: every standard-mode valid pulse must match the next expected word
    always @(negedge clk) begin
        if (reset_i === 1'b1 && s_vld === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL std_unexpected_valid: got data %0h, expected no valid", s_dout);
            end else begin
                chk("std_rd_data", {24'h0, s_dout}, {24'h0, exp_q.pop_front()});
            end
        end
    end

    // Watchdog so the run always ends
    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        reset_i = 1'b0;
        s_flush = 0; s_wr = 0; s_rd = 0; s_clr = 0; s_din = '0;
        f_flush = 0; f_wr = 0; f_rd = 0; f_clr = 0; f_din = '0;
        repeat (2) @(posedge clk);
        #1;
        // Reset state
        chk("rst_count",    s_cnt,   0);
        chk("rst_empty",    s_empty, 1);
        chk("rst_full",     s_full,  0);
        chk("rst_ae",       s_ae,    1);
        chk("rst_af",       s_af,    0);
        chk("rst_vld",      s_vld,   0);
        chk("rst_dout",     s_dout,  0);
        chk("rst_ovf",      s_ovf,   0);
        chk("rst_unf",      s_unf,   0);
        chk("rst_fwft_vld", f_vld,   0);
        @(negedge clk);
        reset_i = 1'b1;

        // Fill 1..8, then one write too many
        for (int i = 1; i <= 8; i++) begin
            s_wr = 1; s_din = 8'(i);
            tick;
            chk("fill_count", s_cnt,  i);
            chk("fill_af",    s_af,   (i >= 6));
            chk("fill_ae",    s_ae,   (i <= 2));
            chk("fill_full",  s_full, (i == 8));
        end
        s_din = 8'd9;
        tick;
        s_wr = 0;
        chk("ovf_set",        s_ovf, 1);
        chk("ovf_count_held", s_cnt, 8);
        chk("std_vld_idle",   s_vld, 0);

        // Drain in order, then one read too many
        for (int i = 1; i <= 8; i++) begin
            s_rd = 1;
            exp_q.push_back(8'(i));
            tick;
            chk("drain_count", s_cnt, 8 - i);
        end
        tick;
        s_rd = 0;
        chk("unf_set",      s_unf,   1);
        chk("unf_vld_low",  s_vld,   0);
        chk("unf_dout_hold",s_dout,  8'd8);
        chk("drain_empty",  s_empty, 1);

        // Clear with a coincident underflow: set wins for underflow
        s_clr = 1; s_rd = 1;
        tick;
        s_rd = 0;
        chk("clr_set_wins_unf", s_unf, 1);
        chk("clr_ovf_cleared",  s_ovf, 0);
        tick;
        s_clr = 0;
        chk("clr_unf_cleared",  s_unf, 0);

        // Concurrent write+read at count 4
        for (int i = 0; i < 4; i++) begin
            s_wr = 1; s_din = 8'(8'h10 + i);
            tick;
        end
        s_wr = 0;
        chk("conc_pre_count", s_cnt, 4);
        for (int i = 0; i < 10; i++) begin
            s_wr = 1; s_rd = 1; s_din = 8'(8'h14 + i);
            exp_q.push_back(8'(8'h10 + i));
            tick;
            chk("conc_count", s_cnt, 4);
        end
        s_wr = 0;
        for (int i = 0; i < 4; i++) begin
            s_rd = 1;
            exp_q.push_back(8'(8'h1A + i));
            tick;
        end
        s_rd = 0;
        chk("conc_empty", s_empty, 1);

        // Pointer wrap with low occupancy
        s_wr = 1; s_din = 8'h40;
        tick;
        for (int i = 1; i < 20; i++) begin
            s_wr = 1; s_rd = 1; s_din = 8'(8'h40 + i);
            exp_q.push_back(8'(8'h40 + i - 1));
            tick;
            chk("wrap_ae",    s_ae,  1);
            chk("wrap_count", s_cnt, 1);
        end
        s_wr = 0; s_rd = 1;
        exp_q.push_back(8'h53);
        tick;
        s_rd = 0;
        chk("wrap_empty", s_empty, 1);

        // Asynchronous reset mid-cycle at count 5
        for (int i = 0; i < 5; i++) begin
            s_wr = 1; s_din = 8'(8'h50 + i);
            tick;
        end
        s_wr = 0;
        chk("rstmid_pre_count", s_cnt, 5);
        #2 reset_i = 1'b0;
        #1;
        chk("rstmid_count", s_cnt,   0);
        chk("rstmid_empty", s_empty, 1);
        @(negedge clk);
        reset_i = 1'b1;
        s_wr = 1; s_din = 8'h77;
        tick;
        s_wr = 0; s_rd = 1;
        exp_q.push_back(8'h77);
        tick;
        s_rd = 0;
        chk("rstmid_post_count", s_cnt, 0);

        // Flush at count 5, with a coincident write that must lose
        for (int i = 0; i < 5; i++) begin
            s_wr = 1; s_din = 8'(8'h60 + i);
            tick;
        end
        chk("flush_pre_count", s_cnt, 5);
        s_flush = 1; s_wr = 1; s_din = 8'h99;
        tick;
        s_flush = 0; s_wr = 0;
        chk("flush_count", s_cnt,   0);
        chk("flush_empty", s_empty, 1);
        chk("flush_vld",   s_vld,   0);
        chk("flush_dout",  s_dout,  8'h77);
        s_wr = 1; s_din = 8'h88;
        tick;
        s_wr = 0; s_rd = 1;
        exp_q.push_back(8'h88);
        tick;
        s_rd = 0;

        // FWFT instance
        f_wr = 1; f_din = 8'hA5;
        tick;
        f_wr = 0;
        chk("fwft_dout",  f_dout, 8'hA5);
        chk("fwft_vld",   f_vld,  1);
        chk("fwft_count", f_cnt,  1);
        f_rd = 1;
        tick;
        chk("fwft_pop_empty", f_empty, 1);
        chk("fwft_pop_vld",   f_vld,   0);
        tick;
        f_rd = 0;
        chk("fwft_unf", f_unf, 1);
        for (int i = 0; i < 9; i++) begin
            f_wr = 1; f_din = 8'(8'hC0 + i);
            tick;
        end
        f_wr = 0;
        chk("fwft_full", f_full, 1);
        chk("fwft_head", f_dout, 8'hC0);
        chk("fwft_ovf",  f_ovf,  1);
        f_clr = 1;
        tick;
        f_clr = 0;
        chk("fwft_clr_ovf", f_ovf, 0);
        chk("fwft_clr_unf", f_unf, 0);
        f_rd = 1;
        tick;
        f_rd = 0;
        chk("fwft_next_head", f_dout, 8'hC1);
        chk("fwft_count7",    f_cnt,  7);

        tick;
        chk("scoreboard_drained", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/sync_fifo_param.md
Name: sync_fifo_param

Overview:
Parametrised single-clock FIFO; the next generation of the team's fixed 3-bit × 8 synchronous FIFO. Adds configurable width and depth, guarded full/empty, programmable almost-full/almost-empty thresholds, a level output, sticky overflow/underflow error flags, a synchronous flush, and a selectable first-word-fall-through (FWFT) read mode. Sits between any same-clock producer and consumer in the datapath.

Parameters:
WIDTH, 8, data word width in bits (≥1)
DEPTH, 8, number of entries; power of two, ≥2
AF_THRESH, DEPTH-2, almost_full_o asserted when count ≥ AF_THRESH
AE_THRESH, 2, almost_empty_o asserted when count ≤ AE_THRESH
FWFT, 0, 0 = standard registered read (1-cycle latency); 1 = first-word-fall-through

Ports:
clk  in  1  clock, all logic on rising edge
reset_i  in  1  asynchronous, active-low reset
flush_i  in  1  synchronous flush: empties the FIFO
wr_en_i  in  1  write request
data_i  in  WIDTH  write data
rd_en_i  in  1  read/pop request
data_o  out  WIDTH  read data
rd_valid_o  out  1  data_o holds valid popped/head data
full_o  out  1  count == DEPTH
empty_o  out  1  count == 0
almost_full_o  out  1  count ≥ AF_THRESH
almost_empty_o  out  1  count ≤ AE_THRESH
count_o  out  $clog2(DEPTH)+1  current occupancy 0..DEPTH
overflow_o  out  1  sticky: write attempted while full
underflow_o  out  1  sticky: read attempted while empty
clr_err_i  in  1  synchronous clear of the sticky error flags

Behaviour:
- Reset (reset_i low, asynchronous): wr_ptr = rd_ptr = 0, count = 0, data_o = 0, rd_valid_o = 0, overflow_o = underflow_o = 0. Hence empty_o = 1, full_o = 0, almost_empty_o = 1, almost_full_o = 0. Memory contents are not reset.
- Pointers are $clog2(DEPTH) bits wide and wrap naturally from DEPTH-1 to 0.
- Flag outputs are combinational decodes of the registered count.
- Write accept: wa = wr_en_i & !full_o. On accept, mem[wr_ptr] ← data_i and wr_ptr + 1.
- Read accept: ra = rd_en_i & !empty_o. On accept, rd_ptr + 1.
- Full and empty guarding uses the pre-edge count. There is no write-through-when-full and no read-through-when-empty.
- Count update: +1 on wa only; −1 on ra only; unchanged when both or neither are accepted. All count updates use non-blocking assignment, and the count never leaves 0..DEPTH.
- Simultaneous wr_en_i and rd_en_i:
  - At 0 < count < DEPTH, both are accepted and count is unchanged.
  - At empty, only the write is accepted and underflow is set.
  - At full, only the read is accepted and overflow is set.
- Sticky errors:
  - overflow_o is set on the edge where wr_en_i & full_o.
  - underflow_o is set on the edge where rd_en_i & empty_o.
  - Both hold until clr_err_i or reset.
  - If clr_err_i and a new error occur in the same cycle, set wins.
- Standard mode (FWFT=0):
  - On ra, data_o ← mem[rd_ptr] at that edge, and rd_valid_o = 1 for exactly that following cycle.
  - Otherwise rd_valid_o = 0 and data_o holds its last value.
- FWFT mode (FWFT=1):
  - data_o = mem[rd_ptr] combinationally and rd_valid_o = !empty_o.
  - rd_en_i acknowledges (pops) the presented word.
  - Write-to-visible latency is 1 cycle (the word is visible once count ≥ 1).
- Flush (flush_i, synchronous, has priority over wr/rd in the same cycle):
  - Resets pointers and count to 0 and clears rd_valid_o.
  - data_o keeps its value in standard mode.
  - Error flags are unaffected.
- Reset mid-operation: all state returns to reset values immediately, without waiting for a clock. The first accepted write after release lands at address 0.
- Elaboration checks: DEPTH must be a power of two ≥2, AF_THRESH must be in 1..DEPTH, and AE_THRESH must be in 0..DEPTH-1. A violation stops elaboration with $error.

Decomposition:
- Shared package/include `fifo_pkg`: clog2-based width constants (PTR_W, CNT_W) and the mode constants FIFO_STD = 0 and FIFO_FWFT = 1.
- One sub-module, `fifo_mem_2p`: a WIDTH×DEPTH simple dual-port register array with a synchronous write port and an asynchronous read port. The top level owns the pointers, count, flags and output register.

Test Plan:
- Write 1..8 (WIDTH=8, DEPTH=8) → full_o=1 after the 8th edge, count_o=8, almost_full_o from count 6. A 9th write → overflow_o=1 and count stays 8.
- Drain 8 reads in standard mode → data_o=1..8 in order, each with a 1-cycle rd_valid_o pulse one cycle after rd_en_i. Then empty_o=1. An extra read → underflow_o=1 and data_o holds 8.
- At count=4, hold wr_en_i and rd_en_i together for 10 cycles → count_o stays 4 and output order is preserved.
- Wrap-around: 20 interleaved writes and reads keeping count ≤3 → all 20 values come out in order across the pointer wrap. almost_empty_o=1 throughout.
- With count=5, pulse reset_i low mid-cycle → count_o=0 and empty_o=1 before the next edge. The next write/read returns the new data, not stale data. A separate run with flush_i at count=5 → count_o=0 on the next edge.
- FWFT=1: write 0xA5 → data_o=0xA5 and rd_valid_o=1 one cycle later with no rd_en_i. Pop → empty_o=1 and rd_valid_o=0. With the error flags set, pulse clr_err_i → both flags clear.
